// File: rtl/plic_claim_master.sv
// plic_claim_master: hart-side PLIC claim/complete initiator driving single-beat AXI4 transactions
module plic_claim_master #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 2,
    parameter logic [AXI_ADDR_WIDTH-1:0] PLIC_BASE      = '0,
    parameter int                        TARGET_ID      = 0,
    parameter int                        SRCW           = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      irq_i,
    output logic                      claim_valid_o,
    output logic [SRCW-1:0]           claim_id_o,
    input  logic                      claim_ready_i,
    input  logic                      complete_valid_i,
    output logic                      complete_ready_o,
    output logic                      err_o,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr_o,
    output logic [7:0]                m_axi_awlen_o,
    output logic [2:0]                m_axi_awsize_o,
    output logic [1:0]                m_axi_awburst_o,
    output logic                      m_axi_awvalid_o,
    input  logic                      m_axi_awready_i,
    output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata_o,
    output logic [3:0]                m_axi_wstrb_o,
    output logic                      m_axi_wlast_o,
    output logic                      m_axi_wvalid_o,
    input  logic                      m_axi_wready_i,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid_i,
    input  logic [1:0]                m_axi_bresp_i,
    input  logic                      m_axi_bvalid_i,
    output logic                      m_axi_bready_o,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [7:0]                m_axi_arlen_o,
    output logic [2:0]                m_axi_arsize_o,
    output logic [1:0]                m_axi_arburst_o,
    output logic                      m_axi_arvalid_o,
    input  logic                      m_axi_arready_i,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]                m_axi_rresp_i,
    input  logic                      m_axi_rlast_i,
    input  logic                      m_axi_rvalid_i,
    output logic                      m_axi_rready_o
);
    localparam logic [AXI_ADDR_WIDTH-1:0] CLAIM_ADDR =
        PLIC_BASE + AXI_ADDR_WIDTH'(32'h0020_0004 + 32'h1000 * TARGET_ID);
    typedef enum logic [2:0] {IDLE, AR, R, DELIVER, WAIT_DONE, WR, B} state_e;
    state_e            state_q, state_d;
    logic [SRCW-1:0]   claim_id_q, claim_id_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              unused_ok;
    // Response id/last are not checked since only one transaction is ever outstanding
    assign unused_ok = ^{m_axi_bid_i, m_axi_rid_i, m_axi_rlast_i};
    // State and registered claim/error/handshake-progress bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            claim_id_q <= '0;
            err_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            claim_id_q <= claim_id_d;
            err_q      <= err_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end
    // Next-state logic; AW and W handshakes are tracked separately so either may finish first
    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        err_d      = 1'b0;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (state_q)
            IDLE:      state_d = irq_i ? AR : IDLE;
            AR:        state_d = m_axi_arready_i ? R : AR;
            R: begin
                if (m_axi_rvalid_i) begin
                    if (m_axi_rresp_i != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (m_axi_rdata_i == '0) begin
                        state_d = IDLE;
                    end else begin
                        claim_id_d = m_axi_rdata_i[SRCW-1:0];
                        state_d    = DELIVER;
                    end
                end
            end
            DELIVER:   state_d = claim_ready_i ? WAIT_DONE : DELIVER;
            WAIT_DONE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = complete_valid_i ? WR : WAIT_DONE;
            end
            WR: begin
                aw_done_d = aw_done_q | m_axi_awready_i;
                w_done_d  = w_done_q | m_axi_wready_i;
                state_d   = (aw_done_d && w_done_d) ? B : WR;
            end
            B: begin
                if (m_axi_bvalid_i) begin
                    err_d   = m_axi_bresp_i != 2'b00;
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end
    assign claim_valid_o    = state_q == DELIVER;
    assign claim_id_o       = claim_id_q;
    assign complete_ready_o = state_q == WAIT_DONE;
    assign err_o            = err_q;
    assign m_axi_arid_o     = '0;
    assign m_axi_araddr_o   = CLAIM_ADDR;
    assign m_axi_arlen_o    = 8'h0;
    assign m_axi_arsize_o   = 3'b010;
    assign m_axi_arburst_o  = 2'b01;
    assign m_axi_arvalid_o  = state_q == AR;
    assign m_axi_rready_o   = state_q == R;
    assign m_axi_awid_o     = '0;
    assign m_axi_awaddr_o   = CLAIM_ADDR;
    assign m_axi_awlen_o    = 8'h0;
    assign m_axi_awsize_o   = 3'b010;
    assign m_axi_awburst_o  = 2'b01;
    assign m_axi_awvalid_o  = (state_q == WR) && !aw_done_q;
    assign m_axi_wdata_o    = AXI_DATA_WIDTH'(claim_id_q);
    assign m_axi_wstrb_o    = 4'hF;
    assign m_axi_wlast_o    = 1'b1;
    assign m_axi_wvalid_o   = (state_q == WR) && !w_done_q;
    assign m_axi_bready_o   = state_q == B;
endmodule

// File: tb/tb_plic_claim_master.sv
// tb_plic_claim_master: randomized handshake-level model check of two plic_claim_master instances
module tb_plic_claim_master;
    logic clk = 0, rst = 1, irq = 0, claim_ready = 0, complete_valid = 0;
    logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 1;
    logic [1:0] bresp = 0, rresp = 0, bid = 0, rid = 0;
    logic [31:0] rdata = 0;
    logic cv[2], cr[2], err[2], awv[2], wv[2], bready[2], arv[2], rready[2], wlast[2];
    logic [4:0] cid[2];
    logic [1:0] awid[2], arid[2], awburst[2], arburst[2];
    logic [31:0] awaddr[2], araddr[2], wdata[2];
    logic [7:0] awlen[2], arlen[2];
    logic [2:0] awsize[2], arsize[2];
    logic [3:0] wstrb[2];
    int checks = 0, errs = 0;
    logic go = 0;
    logic e_arv = 0, e_rr = 0, e_cv = 0, e_cr = 0, e_awv = 0, e_wv = 0, e_br = 0, e_err = 0, busy;
    logic [4:0] e_id = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        plic_claim_master #(.PLIC_BASE(32'h0C00_0000), .TARGET_ID(2 * g)) u_dut (
            .clk_i(clk), .rst_i(rst), .irq_i(irq),
            .claim_valid_o(cv[g]), .claim_id_o(cid[g]), .claim_ready_i(claim_ready),
            .complete_valid_i(complete_valid), .complete_ready_o(cr[g]), .err_o(err[g]),
            .m_axi_awid_o(awid[g]), .m_axi_awaddr_o(awaddr[g]), .m_axi_awlen_o(awlen[g]),
            .m_axi_awsize_o(awsize[g]), .m_axi_awburst_o(awburst[g]), .m_axi_awvalid_o(awv[g]),
            .m_axi_awready_i(awready), .m_axi_wdata_o(wdata[g]), .m_axi_wstrb_o(wstrb[g]),
            .m_axi_wlast_o(wlast[g]), .m_axi_wvalid_o(wv[g]), .m_axi_wready_i(wready),
            .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready[g]),
            .m_axi_arid_o(arid[g]), .m_axi_araddr_o(araddr[g]), .m_axi_arlen_o(arlen[g]),
            .m_axi_arsize_o(arsize[g]), .m_axi_arburst_o(arburst[g]), .m_axi_arvalid_o(arv[g]),
            .m_axi_arready_i(arready), .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
            .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready[g])
        );
    end
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask
    function automatic logic [31:0] claim_addr(input int g);
        return 32'h0C20_0004 + 32'h1000 * 2 * g;
    endfunction
    function automatic logic [255:0] expv(input int g);
        return {e_arv, e_arv ? claim_addr(g) : 32'h0, 2'b00, 8'h00, 3'b010, 2'b01,
                e_rr, e_cv, e_id, e_cr, e_err,
                e_awv, e_awv ? claim_addr(g) : 32'h0, 2'b00, 8'h00, 3'b010, 2'b01,
                e_wv, e_wv ? {27'h0, e_id} : 32'h0, 4'hF, 1'b1, e_br};
    endfunction
    function automatic logic [255:0] actv(input int g);
        return {arv[g], arv[g] ? araddr[g] : 32'h0, arid[g], arlen[g], arsize[g], arburst[g],
                rready[g], cv[g], cid[g], cr[g], err[g],
                awv[g], awv[g] ? awaddr[g] : 32'h0, awid[g], awlen[g], awsize[g], awburst[g],
                wv[g], wv[g] ? wdata[g] : 32'h0, wstrb[g], wlast[g], bready[g]};
    endfunction
    // Handshake-level reference: each cycle advances whichever handshake is currently open
    always @(posedge clk) begin
        busy = e_arv | e_rr | e_cv | e_cr | e_awv | e_wv | e_br;
        e_err = 0;
        if (rst) begin
            {e_arv, e_rr, e_cv, e_cr, e_awv, e_wv, e_br} = '0;
            e_id = 0;
        end else if (!busy) e_arv = irq;
        else if (e_arv) begin
            e_arv = !arready;
            e_rr = arready;
        end else if (e_rr) begin
            if (rvalid) begin
                e_rr = 0;
                if (rresp != 0) e_err = 1;
                else if (rdata != 0) begin
                    e_id = rdata[4:0];
                    e_cv = 1;
                end
            end
        end else if (e_cv) begin
            e_cv = !claim_ready;
            e_cr = claim_ready;
        end else if (e_cr) begin
            e_cr = !complete_valid;
            e_awv = complete_valid;
            e_wv = complete_valid;
        end else if (e_awv | e_wv) begin
            if (awready) e_awv = 0;
            if (wready) e_wv = 0;
            e_br = !e_awv && !e_wv;
        end else if (e_br && bvalid) begin
            e_br = 0;
            e_err = bresp != 0;
        end
    end
    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (go) begin
            chk("model_dut0", actv(0), expv(0));
            chk("model_dut1", actv(1), expv(1));
        end
    end
    initial begin
        repeat (2) @(posedge clk);
        go = 1;
        @(negedge clk);
        chk("reset_idle0", {arv[0], rready[0], cv[0], cr[0], awv[0], wv[0], bready[0], err[0], cid[0]}, 0);
        chk("reset_idle1", {arv[1], rready[1], cv[1], cr[1], awv[1], wv[1], bready[1], err[1], cid[1]}, 0);
        rst = 0;
        irq = 1;
        @(negedge clk);
        chk("ar_addr0", {arv[0], araddr[0]}, {1'b1, 32'h0C20_0004});
        chk("ar_addr1", {arv[1], araddr[1]}, {1'b1, 32'h0C20_2004});
        repeat (5) begin
            @(negedge clk);
            chk("ar_hold", {arv[0], araddr[0]}, {1'b1, 32'h0C20_0004});
        end
        arready = 1;
        irq = 0;
        @(negedge clk);
        arready = 0;
        chk("r_phase", {rready[0], arv[0]}, 2'b10);
        rvalid = 1;
        rdata = 7;
        @(negedge clk);
        rvalid = 0;
        chk("claim7", {cv[0], cid[0]}, {1'b1, 5'd7});
        claim_ready = 1;
        @(negedge clk);
        claim_ready = 0;
        chk("wait_done", {cv[0], cr[0]}, 2'b01);
        complete_valid = 1;
        @(negedge clk);
        complete_valid = 0;
        chk("wr_start", {awv[0], wv[0], awaddr[0], wdata[0]}, {2'b11, 32'h0C20_0004, 32'h7});
        wready = 1;
        @(negedge clk);
        wready = 0;
        chk("w_drop", {awv[0], wv[0]}, 2'b10);
        repeat (2) begin
            @(negedge clk);
            chk("aw_hold", {awv[0], wv[0], bready[0]}, 3'b100);
        end
        awready = 1;
        @(negedge clk);
        awready = 0;
        chk("b_phase", {awv[0], bready[0]}, 2'b01);
        bvalid = 1;
        @(negedge clk);
        bvalid = 0;
        chk("idle_again", {arv[0], bready[0], err[0]}, 0);
        for (int i = 0; i < 4000; i++) begin
            int p;
            p = (i < 2000) ? 3 : 8;
            @(negedge clk);
            rst = ($urandom % 300) == 0;
            irq = ($urandom % 4) != 0;
            arready = e_arv && ($urandom % p == 0);
            rvalid = e_rr && ($urandom % 3 == 0);
            rdata = ($urandom % 5 == 0) ? 32'h0 : $urandom;
            rresp = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            claim_ready = ($urandom % p) == 0;
            complete_valid = ($urandom % p) == 0;
            awready = ($urandom % p) == 0;
            wready = ($urandom % p) == 0;
            bvalid = e_br && ($urandom % 3 == 0);
            bresp = ($urandom % 6 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
